pll_drp_ctrl: RTL and testbench

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

---
 rtl/pll_drp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// Reprograms the PLL MDIV register over the dynamic port for PAL/NTSC, verifies it by readback,
// then pulses the PLL reset and waits, with a timeout, for the PLL to relock.
module pll_drp_ctrl #(
   parameter logic [7:0] MDIV_ADDR    = 8'h0D,
   parameter logic [7:0] MDIV_PAL     = 8'd34,
   parameter logic [7:0] MDIV_NTSC    = 8'd35,
   parameter int         RST_CYCLES   = 16,
   parameter int         LOCK_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       mode,
   input  logic       lock,
   input  logic [7:0] mdrdo,
   output logic [1:0] mdopc,
   output logic       mdainc,
   output logic [7:0] mdwdi,
   output logic       pll_reset,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       mode_cur
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_CMP, PLL_RST, WAIT_LOCK
   } state_t;

   localparam logic [1:0]  OP_NOP   = 2'b00;
   localparam logic [1:0]  OP_WRITE = 2'b01;
   localparam logic [1:0]  OP_READ  = 2'b10;
   localparam logic [4:0]  RST_LAST = 5'(RST_CYCLES - 1);
   localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] LOCK_MASK = 16'd4;

   state_t      state_q, state_d;
   logic        tgt_q, tgt_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [4:0]  rst_cnt_q, rst_cnt_d;
   logic [15:0] lock_cnt_q, lock_cnt_d;
   logic [1:0]  mdopc_q, mdopc_d;
   logic [7:0]  mdwdi_q, mdwdi_d;
   logic        pll_reset_q, pll_reset_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mode_cur_q, mode_cur_d;
   logic        lock_meta_q, lock_s_q;

   // Port outputs are computed for the state being entered, so they line up with state_q.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      data_d      = data_q;
      rdata_d     = rdata_q;
      rst_cnt_d   = rst_cnt_q;
      lock_cnt_d  = lock_cnt_q;
      mdopc_d     = OP_NOP;
      mdwdi_d     = 8'h00;
      pll_reset_d = pll_reset_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      mode_cur_d  = mode_cur_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               tgt_d   = mode;
               data_d  = mode ? MDIV_NTSC : MDIV_PAL;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = WR_ADDR;
               mdopc_d = OP_WRITE;
               mdwdi_d = MDIV_ADDR;
            end
         end
         WR_ADDR: begin
            state_d = WR_DATA;
            mdwdi_d = data_q;
         end
         WR_DATA: begin
            state_d = RD_ADDR;
            mdopc_d = OP_READ;
            mdwdi_d = MDIV_ADDR;
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            rdata_d = mdrdo;
            state_d = RD_CMP;
         end
         RD_CMP: begin
            if (rdata_q == data_q) begin
               state_d     = PLL_RST;
               pll_reset_d = 1'b1;
               rst_cnt_d   = 5'd0;
            end else begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         PLL_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               pll_reset_d = 1'b0;
               lock_cnt_d  = 16'd0;
               state_d     = WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + 5'd1;
            end
         end
         WAIT_LOCK: begin
            // Lock is tested before the timeout so a coincident lock still completes.
            if (lock_cnt_q >= LOCK_MASK && lock_s_q) begin
               done_d     = 1'b1;
               mode_cur_d = tgt_q;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else if (lock_cnt_q >= TMO_LAST) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (lock_cnt_q != 16'hFFFF) begin
               lock_cnt_d = lock_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tgt_q       <= 1'b0;
         data_q      <= 8'h00;
         rdata_q     <= 8'h00;
         rst_cnt_q   <= 5'd0;
         lock_cnt_q  <= 16'd0;
         mdopc_q     <= OP_NOP;
         mdwdi_q     <= 8'h00;
         pll_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mode_cur_q  <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         data_q      <= data_d;
         rdata_q     <= rdata_d;
         rst_cnt_q   <= rst_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         mdopc_q     <= mdopc_d;
         mdwdi_q     <= mdwdi_d;
         pll_reset_q <= pll_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mode_cur_q  <= mode_cur_d;
         lock_meta_q <= lock;
         lock_s_q    <= lock_meta_q;
      end
   end

   assign mdopc     = mdopc_q;
   assign mdainc    = 1'b0;
   assign mdwdi     = mdwdi_q;
   assign pll_reset = pll_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mode_cur  = mode_cur_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Randomised scoreboard bench for pll_drp_ctrl: stimulus predicts each sequence outcome,
// a negedge monitor pops and compares when the sequence finishes.
`timescale 1ns/1ps
module tb_pll_drp_ctrl;

   localparam int         T    = 100;
   localparam logic [7:0] PAL  = 8'd34;
   localparam logic [7:0] NTSC = 8'd35;
   localparam logic [7:0] ADDR = 8'h0D;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       req = 1'b0, mode = 1'b0, lock = 1'b0;
   logic [7:0] mdrdo = 8'h00;
   logic [1:0] mdopc;
   logic       mdainc;
   logic [7:0] mdwdi;
   logic       pll_reset, busy, done, err, mode_cur;

   always #5 clk = ~clk;

   pll_drp_ctrl #(.LOCK_TIMEOUT(T)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .mode(mode), .lock(lock), .mdrdo(mdrdo),
      .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .pll_reset(pll_reset),
      .busy(busy), .done(done), .err(err), .mode_cur(mode_cur)
   );

   typedef struct {
      bit         is_done;
      bit         mode_cur;
      int         busy_cyc;
      int         rst_cyc;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;
   bit   cur_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outcome from the sequence rules: 5 handshake cycles, 16 reset cycles, then lock
   // accepted from the 5th WAIT_LOCK cycle on, seen 2 cycles after the pin rises.
   function automatic exp_t predict(bit m, logic [7:0] rd, int lock_off, bit stale, bit cur);
      exp_t e;
      int   first_ls, k;
      e.d = m ? NTSC : PAL;
      if (rd != e.d) begin
         e.is_done = 0; e.mode_cur = cur; e.busy_cyc = 5; e.rst_cyc = 0;
         return e;
      end
      e.rst_cyc = 16;
      first_ls  = stale ? 0 : (lock_off < 0 ? 1 << 30 : lock_off + 2);
      k         = (first_ls < 4) ? 4 : first_ls;
      if (k <= T - 1) begin
         e.is_done = 1; e.mode_cur = m; e.busy_cyc = 5 + 16 + k + 1;
      end else begin
         e.is_done = 0; e.mode_cur = cur; e.busy_cyc = 5 + 16 + T;
      end
      return e;
   endfunction

   // Monitor
   bit         active = 0, prev_err = 0, prev_done = 0, sticky_exp = 0;
   int         bc = 0, rc = 0;
   logic [9:0] tr[3];

   always @(negedge clk) begin
      if (!reset_n) begin
         active = 0; prev_err = 0; prev_done = 0; sticky_exp = 0;
      end else begin
         if (busy && !active) begin
            active = 1; bc = 0; rc = 0;
            chk("err_sticky_until_req", 32'(prev_err), 32'(sticky_exp));
            chk("err_clear_on_accept", 32'(err), 0);
         end
         if (busy) begin
            if (bc < 3) tr[bc] = {mdopc, mdwdi};
            if (pll_reset) rc++;
            bc++;
         end
         if (done && err) chk("done_err_exclusive", 1, 0);
         if (prev_done) chk("done_single_pulse", 32'(done), 0);
         if (active && !busy) begin
            active = 0;
            if (sb.size() == 0) chk("unexpected_completion", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("done", 32'(done), 32'(e.is_done));
               chk("err", 32'(err), 32'(!e.is_done));
               chk("mode_cur", 32'(mode_cur), 32'(e.mode_cur));
               chk("busy_cycles", 32'(bc), 32'(e.busy_cyc));
               chk("pll_reset_cycles", 32'(rc), 32'(e.rst_cyc));
               chk("op_wr_addr", 32'(tr[0]), 32'({2'b01, ADDR}));
               chk("op_wr_data", 32'(tr[1]), 32'({2'b00, e.d}));
               chk("op_rd_addr", 32'(tr[2]), 32'({2'b10, ADDR}));
               sticky_exp = !e.is_done;
            end
         end
         prev_err  = err;
         prev_done = done;
      end
   end

   task automatic run_txn(bit m, logic [7:0] rd, int lock_off, bit stale, int busy_req_at, bit do_reset);
      exp_t e;
      int   g;
      lock = stale; mdrdo = rd;
      repeat (4) @(posedge clk);
      #1 req = 1; mode = m;
      @(posedge clk);
      #1 req = 0; mode = 1'($urandom);
      e = predict(m, rd, lock_off, stale, cur_mode);
      if (!do_reset) sb.push_back(e);
      if (busy_req_at >= 0) begin
         repeat (busy_req_at) @(posedge clk);
         #1 req = 1; mode = !m;
         @(posedge clk);
         #1 req = 0;
      end
      if (e.rst_cyc > 0 || do_reset) begin
         g = 0;
         while (pll_reset !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
         if (g >= 50) chk("wait_pll_reset_rise", 0, 1);
         if (do_reset) begin
            repeat (5) @(posedge clk);
            #1 reset_n = 0;
            #1;
            chk("rst_mid_pll_reset", 32'(pll_reset), 0);
            chk("rst_mid_busy", 32'(busy), 0);
            chk("rst_mid_mdopc", 32'(mdopc), 0);
            chk("rst_mid_mdwdi", 32'(mdwdi), 0);
            chk("rst_mid_mode_cur", 32'(mode_cur), 0);
            cur_mode = 0;
            repeat (2) @(posedge clk);
            #1 reset_n = 1;
            return;
         end
         g = 0;
         while (pll_reset !== 1'b0 && g < 40) begin @(posedge clk); #1; g++; end
         if (g >= 40) chk("wait_pll_reset_fall", 1, 0);
         if (!stale && lock_off >= 0) begin
            repeat (lock_off) @(posedge clk);
            #1 lock = 1;
         end
      end
      g = 0;
      while (busy !== 1'b0 && g < 300) begin @(posedge clk); #1; g++; end
      if (g >= 300) chk("wait_busy_fall", 1, 0);
      if (e.is_done) cur_mode = m;
      lock = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset_n = 0;
      #10;
      chk("reset_mdopc", 32'(mdopc), 0);
      chk("reset_mdwdi", 32'(mdwdi), 0);
      chk("reset_mdainc", 32'(mdainc), 0);
      chk("reset_pll_reset", 32'(pll_reset), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_mode_cur", 32'(mode_cur), 0);
      @(posedge clk); #1 reset_n = 1;

      run_txn(1, NTSC, 20, 0, -1, 0);      // PAL to NTSC
      run_txn(0, PAL, 7, 0, -1, 0);        // back to PAL
      run_txn(1, PAL, 20, 0, -1, 0);       // readback mismatch
      run_txn(1, NTSC, -1, 0, -1, 0);      // lock timeout
      run_txn(1, NTSC, 0, 1, -1, 0);       // stale lock held high
      run_txn(0, PAL, T - 3, 0, -1, 0);    // lock on the timeout cycle
      run_txn(1, NTSC, T - 2, 0, -1, 0);   // lock one cycle late
      run_txn(1, NTSC, 3, 0, 2, 0);        // req while busy
      run_txn(0, PAL, 5, 0, -1, 1);        // reset during PLL_RST
      run_txn(1, NTSC, 10, 0, -1, 0);      // recovers after reset

      for (int i = 0; i < 30; i++) begin
         bit         m, stale, bad;
         logic [7:0] d, rd;
         int         off, br;
         m     = 1'($urandom);
         d     = m ? NTSC : PAL;
         bad   = ($urandom % 4) == 0;
         rd    = bad ? (d ^ 8'($urandom_range(1, 255))) : d;
         stale = ($urandom % 5) == 0;
         off   = (($urandom % 6) == 0) ? -1 : int'($urandom_range(0, 105));
         br    = (($urandom % 3) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_txn(m, rd, off, stale, br, 0);
      end

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
